// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC job scheduler.
package cordic_sched_pkg;

  localparam int FLOAT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Queued job: function select plus float32 angle (33 bits).
  typedef struct packed {
    logic               cos;
    logic [FLOAT_W-1:0] theta;
  } cmd_entry_t;

  // Completed job: timeout flag, core invalid flag, float32 result (34 bits).
  typedef struct packed {
    logic               err;
    logic               invalid;
    logic [FLOAT_W-1:0] result;
  } rsp_entry_t;

endpackage

// File: rtl/cordic_job_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// Pointers carry one extra MSB so full and empty are distinguishable.
module cordic_job_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush empties the FIFO and overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers define which words are valid,
    // and leaving the array unreset lets it map onto plain RAM/flops.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cordic_job_scheduler.sv
// Queues sin/cos jobs and issues them one at a time to the shared CORDIC core,
// collecting results (or timeout errors) into a response FIFO.
module cordic_job_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64,
  parameter int IRQ_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FLOAT_W-1:0]     cmd_theta,
  input  logic                   cmd_cos,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FLOAT_W-1:0]     rsp_result,
  output logic                   rsp_invalid,
  output logic                   rsp_err,
  input  logic                   flush,
  input  logic                   err_clr,
  output logic [FLOAT_W-1:0]     core_theta,
  output logic                   core_cos,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [FLOAT_W-1:0]     core_result,
  input  logic                   core_invalid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] cmd_count,
  output logic [$clog2(DEPTH):0] rsp_count,
  output logic                   irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] IRQ_LEVEL  = CW'(IRQ_THRESH);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               err_sticky_q, err_sticky_d;
  logic [FLOAT_W-1:0] core_theta_q, core_theta_d;
  logic               core_cos_q, core_cos_d;

  cmd_entry_t cmd_wdata, cmd_head;
  rsp_entry_t rsp_wdata, rsp_head;
  logic       cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic       cmd_push, can_issue, issue, rsp_push, set_err, timeout;

  // Flush beats a simultaneous push; the issue check on response space
  // guarantees the response FIFO never overflows.
  assign cmd_wdata = '{cos: cmd_cos, theta: cmd_theta};
  assign cmd_push  = cmd_valid & ~cmd_full & ~flush;
  assign can_issue = ~cmd_empty & ~rsp_full & ~flush;
  assign timeout   = (timer_q == TIMER_LAST);

  cordic_job_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (issue),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  cordic_job_fifo #(.WIDTH($bits(rsp_entry_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_ready),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      err_sticky_q <= 1'b0;
      core_theta_q <= '0;
      core_cos_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      err_sticky_q <= err_sticky_d;
      core_theta_q <= core_theta_d;
      core_cos_q   <= core_cos_d;
    end
  end

  // Next-state logic; a done pulse coinciding with flush returns straight to IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (can_issue) state_d = BUSY;
      BUSY: begin
        if (flush)                    state_d = core_done ? IDLE : DRAIN;
        else if (core_done | timeout) state_d = IDLE;
      end
      DRAIN:   if (core_done | timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: core handshake, issue strobe and response push.
  always_comb begin
    core_start = (state_q == BUSY);
    busy       = (state_q != IDLE);
    issue      = (state_q == IDLE) & can_issue;
    rsp_push   = (state_q == BUSY) & ~flush & (core_done | timeout);
    set_err    = (state_q == BUSY) & ~flush & ~core_done & timeout;
    rsp_wdata  = '{err: 1'b1, invalid: 1'b0, result: '0};
    if (core_done) rsp_wdata = '{err: 1'b0, invalid: core_invalid, result: core_result};
  end

  // Timer, sticky error and core operand capture; a new timeout beats err_clr.
  always_comb begin
    timer_d      = timer_q;
    err_sticky_d = err_sticky_q;
    core_theta_d = core_theta_q;
    core_cos_d   = core_cos_q;
    if (issue) begin
      timer_d      = '0;
      core_theta_d = cmd_head.theta;
      core_cos_d   = cmd_head.cos;
    end else if (state_q != IDLE) begin
      timer_d = timer_q + TW'(1);
    end
    if (set_err)      err_sticky_d = 1'b1;
    else if (err_clr) err_sticky_d = 1'b0;
  end

  assign cmd_ready   = ~cmd_full;
  assign rsp_valid   = ~rsp_empty;
  assign rsp_result  = rsp_empty ? '0 : rsp_head.result;
  assign rsp_invalid = ~rsp_empty & rsp_head.invalid;
  assign rsp_err     = ~rsp_empty & rsp_head.err;
  assign core_theta  = core_theta_q;
  assign core_cos    = core_cos_q;
  assign irq         = (rsp_count >= IRQ_LEVEL) | err_sticky_q;

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Self-checking bench for cordic_job_scheduler: directed vectors, multi-cycle
// corner sequences and a randomized run against a queue-based reference.
module tb_cordic_job_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_cos;
  logic [31:0] cmd_theta;
  logic        rsp_valid, rsp_ready, rsp_invalid, rsp_err;
  logic [31:0] rsp_result;
  logic        flush, err_clr;
  logic [31:0] core_theta, core_result;
  logic        core_cos, core_start, core_done, core_invalid;
  logic        busy, irq;
  logic [2:0]  cmd_count, rsp_count;

  cordic_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IRQ_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_theta(cmd_theta), .cmd_cos(cmd_cos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_invalid(rsp_invalid), .rsp_err(rsp_err),
    .flush(flush), .err_clr(err_clr),
    .core_theta(core_theta), .core_cos(core_cos), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .core_invalid(core_invalid),
    .busy(busy), .cmd_count(cmd_count), .rsp_count(rsp_count), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  // fixed_lat > 0: respond after that many start cycles; -1: never respond;
  // 0: latency derived from the angle (low nibble + 1, never if bits [7:4] = 0xF).
  int          fixed_lat = 1;
  logic        core_hold = 1'b0;
  int          core_cnt;
  logic        model_done, model_invalid;
  logic [31:0] model_result;
  logic        man_done = 1'b0;
  logic [31:0] man_result = 32'h0;

  function automatic logic [31:0] core_fn(input logic [31:0] th, input logic c);
    if (th[30:23] == 8'hFF)         return 32'h7FC0_0000;
    if (th == 32'h3F00_0000 && c)   return 32'h3F60_A8B4;
    return th ^ (c ? 32'h5A5A_5A5A : 32'h0F0F_0F0F);
  endfunction

  function automatic int lat_of(input logic [31:0] th);
    if (fixed_lat != 0)   return fixed_lat;
    if (th[7:4] == 4'hF)  return -1;
    return int'(th[3:0]) + 1;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done = 1'b0; core_cnt = 0; model_result = '0; model_invalid = 1'b0;
    end else begin
      model_done = 1'b0;
      if (!core_start) core_cnt = 0;
      else if (!core_hold) begin
        core_cnt++;
        if (core_cnt == lat_of(core_theta)) begin
          model_done    = 1'b1;
          model_result  = core_fn(core_theta, core_cos);
          model_invalid = (core_theta[30:23] == 8'hFF);
        end
      end
    end
  end

  assign core_done    = model_done | man_done;
  assign core_result  = man_done ? man_result : model_result;
  assign core_invalid = man_done ? 1'b0 : model_invalid;

  // Length of the most recent core_start high run, in cycles.
  int cur_run = 0;
  int start_run = 0;
  always @(negedge clk) begin
    if (core_start) cur_run++;
    else begin
      if (cur_run != 0) start_run = cur_run;
      cur_run = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic push_job(input logic [31:0] th, input logic c);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_theta = th; cmd_cos = c;
    k = 0;
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    if (!cmd_ready) check("push_ready_wait", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int k = 0;
    while (!rsp_valid && k < 300) begin @(negedge clk); k++; end
    check(name, rsp_valid, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, rsp_valid, rsp_invalid, rsp_err, core_cos, core_start, busy, irq},
          8'b1000_0000);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_core_theta"}, core_theta, 0);
    check({tag, "_counts"}, {cmd_count, rsp_count}, 0);
  endtask

  typedef struct {
    logic [31:0] theta;
    logic        cosf;
    int          lat;
    logic [31:0] exp_result;
    logic        exp_inv;
    logic        exp_err;
    int          exp_run;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    string n;
    n = $sformatf("vec%0d", idx);
    fixed_lat = v.lat;
    push_job(v.theta, v.cosf);
    check({n, "_cmd_count_after_push"}, cmd_count, 1);
    check({n, "_start_low_at_push"}, core_start, 0);
    @(posedge clk); #1;
    check({n, "_start_busy"}, {core_start, busy, cmd_count}, {1'b1, 1'b1, 3'd0});
    check({n, "_core_operands"}, {core_cos, core_theta}, {v.cosf, v.theta});
    wait_rsp({n, "_rsp_wait"});
    @(posedge clk); #1;
    check({n, "_rsp"}, {rsp_err, rsp_invalid, rsp_result}, {v.exp_err, v.exp_inv, v.exp_result});
    check({n, "_start_run"}, start_run, v.exp_run);
    check({n, "_irq_pending"}, irq, 1);
    pop_rsp();
    check({n, "_empty_after_pop"}, rsp_valid, 0);
    check({n, "_irq_after_pop"}, irq, v.exp_err);
    if (v.exp_err) begin
      pulse_err_clr();
      check({n, "_irq_after_err_clr"}, irq, 0);
    end
  endtask

  // Reference for the randomized run: jobs answer in acceptance order; each
  // answer follows from its own angle via the core rules above.
  logic [32:0] exp_q[$];

  task automatic check_rsp_head();
    logic [32:0] job;
    logic [33:0] exp;
    if (exp_q.size() == 0) begin
      check("rnd_unexpected_rsp", exp_q.size(), 1);
      return;
    end
    job = exp_q.pop_front();
    if (job[7:4] == 4'hF) exp = {1'b1, 1'b0, 32'h0};
    else exp = {1'b0, job[30:23] == 8'hFF, core_fn(job[31:0], job[32])};
    check("rnd_rsp", {rsp_err, rsp_invalid, rsp_result}, exp);
  endtask

  vec_t vecs[6];

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h3F00_0000, 1'b1, 20, 32'h3F60_A8B4, 1'b0, 1'b0, 20};
    vecs[1] = '{32'h7F80_0000, 1'b0, 5,  32'h7FC0_0000, 1'b1, 1'b0, 5};
    vecs[2] = '{32'h4049_0FDB, 1'b0, 1,  32'h4F46_00D4, 1'b0, 1'b0, 1};
    vecs[3] = '{32'h3F80_0000, 1'b1, -1, 32'h0,         1'b0, 1'b1, 64};
    vecs[4] = '{32'hBF00_0000, 1'b0, 63, 32'hB00F_0F0F, 1'b0, 1'b0, 63};
    vecs[5] = '{32'h3E80_0000, 1'b1, 64, 32'h64DA_5A5A, 1'b0, 1'b0, 64};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_theta = '0; cmd_cos = 1'b0;
    rsp_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors: normal, invalid, timeout and latency boundaries.
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Back-pressure: stalled core, 1 in flight + 4 queued, 6th refused.
    fixed_lat = 3; core_hold = 1'b1;
    for (int i = 1; i <= 5; i++) push_job(32'(i), 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_theta = 32'd6; cmd_cos = 1'b0;
    check("bp_sixth_refused", cmd_ready, 0);
    @(posedge clk); #1; cmd_valid = 1'b0;
    check("bp_cmd_count_full", cmd_count, 4);
    core_hold = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("bp_rsp_full_stall", {rsp_count, core_start, busy, cmd_count}, {3'd4, 1'b0, 1'b0, 3'd1});
    push_job(32'd6, 1'b0);
    check("bp_cmd_count_2", cmd_count, 2);
    check("bp_rsp1", rsp_result, core_fn(32'd1, 1'b0));
    pop_rsp();
    check("bp_no_issue_at_pop_edge", core_start, 0);
    @(posedge clk); #1;
    check("bp_job5_issued", {core_start, core_theta}, {1'b1, 32'd5});
    for (int i = 2; i <= 6; i++) begin
      wait_rsp($sformatf("bp_rsp%0d_wait", i));
      check($sformatf("bp_rsp%0d", i), {rsp_err, rsp_result}, {1'b0, core_fn(32'(i), 1'b0)});
      pop_rsp();
    end

    // Flush mid-job with two queued; late done lands in DRAIN and is dropped.
    fixed_lat = 4; core_hold = 1'b1;
    push_job(32'hAAAA_0001, 1'b0);
    @(posedge clk); #1;
    check("fl_busy", core_start, 1);
    push_job(32'hAAAA_0002, 1'b1);
    push_job(32'hAAAA_0003, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("fl_queued", cmd_count, 2);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("fl_drain", {busy, core_start, cmd_count, rsp_count}, {1'b1, 1'b0, 3'd0, 3'd0});
    repeat (2) @(negedge clk);
    @(negedge clk); man_done = 1'b1; man_result = 32'h1234_5678;
    @(posedge clk); #1; man_done = 1'b0;
    check("fl_idle_no_rsp", {busy, rsp_valid, rsp_count}, {1'b0, 1'b0, 3'd0});
    repeat (2) @(posedge clk);
    #1;
    check("fl_stays_idle", {busy, core_start, cmd_count}, {1'b0, 1'b0, 3'd0});
    core_hold = 1'b0;
    run_vec(10, '{32'h3F00_0000, 1'b1, 7, 32'h3F60_A8B4, 1'b0, 1'b0, 7});

    // Async reset while busy with three responses held.
    fixed_lat = 2;
    for (int i = 0; i < 3; i++) push_job(32'h0100_0000 + 32'(i), 1'b1);
    for (int k = 0; k < 100 && rsp_count != 3; k++) @(negedge clk);
    check("ar_three_rsps", rsp_count, 3);
    core_hold = 1'b1;
    push_job(32'h0200_0000, 1'b0);
    @(posedge clk); #1;
    check("ar_busy_before_reset", {core_start, irq}, 2'b11);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    check_reset_vals("async_reset");
    @(negedge clk); rst_n = 1'b1; core_hold = 1'b0;
    run_vec(11, '{32'h4049_0FDB, 1'b1, 9, 32'h1A13_5581, 1'b0, 1'b0, 9});

    // Randomized traffic against the in-order reference.
    fixed_lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_theta = $urandom;
      cmd_cos   = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (rsp_valid && rsp_ready) check_rsp_head();
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_cos, cmd_theta});
    end
    @(negedge clk); cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && exp_q.size() != 0; cyc++) begin
      if (rsp_valid) check_rsp_head();
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("rnd_all_answered", exp_q.size(), 0);
    pulse_err_clr();
    check("rnd_quiet_end", {busy, rsp_valid, irq}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_job_scheduler.md
# cordic_job_scheduler

Job scheduler for the CORDIC trigonometry core. It accepts sin/cos jobs (float32 angle plus function select) into a command FIFO and issues them one at a time to the single shared core using its start-level / done-pulse protocol. Results are collected into a response FIFO, and a status interrupt is raised. It sits between the TinyQV peripheral register front-end and the core, so software can queue several angles without polling each one.

## Interface
Parameters:
- DEPTH, 4, entries in each of the command and response FIFOs; power of 2, ≥2
- TIMEOUT, 64, cycles allowed from start to core done before the job is aborted
- IRQ_THRESH, 1, response count at or above which irq asserts

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  job offered
- cmd_ready  out  1  job accepted when both valid and ready are high; equals !cmd_full
- cmd_theta  in  32  float32 angle
- cmd_cos  in  1  1 = cos, 0 = sin
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  pop the head response
- rsp_result  out  32  head result
- rsp_invalid  out  1  head job flagged invalid by the core
- rsp_err  out  1  head job timed out; rsp_result = 0
- flush  in  1  synchronous; discard all queued and in-flight work
- err_clr  in  1  clear sticky error
- core_theta  out  32  angle to core, registered
- core_cos  out  1  function select to core, registered
- core_start  out  1  held high while the job is in flight
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  32  core result, valid with core_done
- core_invalid  in  1  invalid-input flag, sampled with core_done
- busy  out  1  state != IDLE
- cmd_count  out  $clog2(DEPTH)+1  command FIFO occupancy
- rsp_count  out  $clog2(DEPTH)+1  response FIFO occupancy
- irq  out  1  (rsp_count ≥ IRQ_THRESH) | err_sticky

Reset values: all outputs 0 except cmd_ready=1. Both FIFOs are emptied, state is IDLE, and timer and err_sticky are 0.

## Operation
States:
- IDLE: core_start=0. Moves to BUSY when the command FIFO is non-empty and the response FIFO is not full, all evaluated at the same edge. At that edge the head command is popped into core_theta/core_cos, and the timer is cleared.
- BUSY: core_start=1; core_theta/core_cos held stable.
  - core_done=1: push {err=0, core_invalid, core_result} → IDLE.
  - Timer reaches TIMEOUT-1 without done: push {err=1, invalid=0, result=0}, set err_sticky → IDLE.
  - flush: → DRAIN; nothing pushed.
- DRAIN: core_start=0. On core_done or timer expiry → IDLE; the result is discarded.

Rules:
- Only one job is in flight. The issue check on response-FIFO fullness guarantees no response overflow.
- IDLE always lasts ≥1 cycle between jobs, so core_start drops for ≥1 cycle and the core re-arms.
- Simultaneous core_done and flush in BUSY: result discarded, → IDLE.
- Simultaneous flush and cmd push: flush wins, push dropped. Flush and rsp pop: both FIFOs end empty.
- Simultaneous rsp push and pop: both happen; count unchanged.
- cmd push when full: impossible because cmd_ready=0. Pushing while the core pops the head in the same cycle is allowed when not full.
- err_clr and a new timeout in the same cycle: set wins.
- Async reset mid-job: immediate return to reset values; the core is reset by the same rst_n.

## Timing
- Push accepted at edge N into an idle, empty scheduler: cmd_count=1 after N; IDLE→BUSY at N+1; core_start high from N+1.
- core_done sampled at edge M: rsp_valid high after M; core_start low after M. The next job's start comes at the earliest M+1 edge, giving one low cycle.
- Timeout: abort at edge issue+TIMEOUT; rsp_err visible the following cycle.
- Response head is first-word-fall-through from registered storage, with no read latency.
- Counters wrap modulo DEPTH on the pointers; occupancy uses the extra MSB.

## Structure
- Package cordic_sched_pkg:
  - state enum {IDLE, BUSY, DRAIN}
  - rsp entry struct {err, invalid, result[31:0]} (34 bits)
  - FLOAT_W=32
- Sub-module cordic_job_fifo: parameterised WIDTH/DEPTH synchronous FIFO with count, full, empty and flush. Instantiated twice: command at 33 bits, response at 34 bits.
- Timer: $clog2(TIMEOUT)-bit counter in the top level.

## Test plan
- Single job: push theta=0x3F000000, cos=1; core model returns done with 0x3F60A8B4 after 20 cycles → core_start high from the push edge +1; rsp_result=0x3F60A8B4, rsp_invalid=0, rsp_err=0; irq=1 until pop.
- Back-pressure: stall the core and push 6 jobs with theta = 1..6 → the 6th is refused with cmd_ready=0 (1 in flight + 4 queued). With no pops, after 4 completions core_start stays low while rsp_count=4. Pop one → 5th job issues. All responses arrive in order 1..6.
- Timeout: core never completes → core_start drops exactly 64 cycles after rising; response err=1, result=0; irq=1 after the pop too, until err_clr.
- Invalid input: core returns done with core_invalid=1, result 0x7FC00000 → rsp_invalid=1, rsp_err=0.
- Flush mid-job: flush 5 cycles into BUSY with 2 queued, and core_done arrives 3 cycles later → DRAIN then IDLE; cmd_count=rsp_count=0; no response. Next job completes normally.
- Async reset: assert rst_n low between clock edges while BUSY with 3 responses → all outputs reach reset values before the next edge; after release, a new job completes correctly.
